// File: rtl/hack_cpu_param.sv
// Multi-cycle Hack CPU core with a handshaked instruction port, a single-outstanding
// data-memory port, a retired-instruction counter and optional halt-loop detection.
module hack_cpu_param #(
    parameter int DATA_W      = 16,
    parameter int PC_W        = 15,
    parameter int CNT_W       = 16,
    parameter int HALT_DETECT = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic              instr_req,
    input  logic              instr_valid,
    input  logic [15:0]       instruction,
    output logic [PC_W-1:0]   pc,
    output logic              mem_req,
    output logic              mem_we,
    input  logic              mem_ack,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              halted,
    output logic [CNT_W-1:0]  retired
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_MEM_RD, S_EXEC, S_MEM_WR, S_HALT
    } state_t;

    state_t             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [DATA_W-1:0]  a_q, a_d, d_q, d_d;
    logic [DATA_W-1:0]  addr_q, addr_d, y_q, y_d;
    logic [15:0]        ir_q, ir_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic               halted_q, halted_d, prev_a_q, prev_a_d;
    logic               mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;

    logic signed [DATA_W-1:0] alu_res;
    logic                     zero, neg, jump_tk, halt_hit;
    logic [PC_W-1:0]          target, pc_inc;
    logic [CNT_W-1:0]         retired_inc;

    function automatic logic [DATA_W-1:0] hack_alu(input logic [DATA_W-1:0] x,
                                                   input logic [DATA_W-1:0] y,
                                                   input logic [5:0]        c);
        logic [DATA_W-1:0] xa, ya, r;
        xa = c[5] ? '0 : x;
        xa = c[4] ? ~xa : xa;
        ya = c[3] ? '0 : y;
        ya = c[2] ? ~ya : ya;
        r  = c[1] ? xa + ya : xa & ya;
        return c[0] ? ~r : r;
    endfunction

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        a_d         = a_q;
        d_d         = d_q;
        addr_d      = addr_q;
        y_d         = y_q;
        ir_d        = ir_q;
        retired_d   = retired_q;
        halted_d    = halted_q;
        prev_a_d    = prev_a_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_wdata_d = mem_wdata_q;

        alu_res     = hack_alu(d_q, y_q, ir_q[11:6]);
        zero        = (alu_res == '0);
        neg         = alu_res[DATA_W-1];
        jump_tk     = (ir_q[2] & neg) | (ir_q[1] & zero) | (ir_q[0] & ~neg & ~zero);
        target      = addr_q[PC_W-1:0];
        pc_inc      = pc_q + PC_W'(1);
        retired_inc = retired_q + CNT_W'(1);
        // A self-jump, or a two-instruction "@L; 0;JMP" loop back onto itself, can never exit.
        halt_hit    = (HALT_DETECT != 0) && jump_tk && (ir_q[5:3] == 3'b000) &&
                      ((target == pc_q) || (prev_a_q && (target == pc_q - PC_W'(1))));

        case (state_q)
            S_FETCH: begin
                if (instr_valid) begin
                    ir_d    = instruction;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!ir_q[15]) begin
                    a_d       = DATA_W'(ir_q[14:0]);
                    pc_d      = pc_inc;
                    retired_d = retired_inc;
                    prev_a_d  = 1'b1;
                    state_d   = S_FETCH;
                end else begin
                    // Operand address and jump target are frozen here, before d1 can rewrite A.
                    addr_d = a_q;
                    if (ir_q[12]) begin
                        mem_req_d = 1'b1;
                        mem_we_d  = 1'b0;
                        state_d   = S_MEM_RD;
                    end else begin
                        y_d     = a_q;
                        state_d = S_EXEC;
                    end
                end
            end
            S_MEM_RD: begin
                if (mem_ack) begin
                    y_d       = mem_rdata;
                    mem_req_d = 1'b0;
                    state_d   = S_EXEC;
                end
            end
            S_EXEC: begin
                if (ir_q[5]) a_d = alu_res;
                if (ir_q[4]) d_d = alu_res;
                if (halt_hit) begin
                    retired_d = retired_inc;
                    halted_d  = 1'b1;
                    prev_a_d  = 1'b0;
                    state_d   = S_HALT;
                end else begin
                    pc_d = jump_tk ? target : pc_inc;
                    if (ir_q[3]) begin
                        mem_req_d   = 1'b1;
                        mem_we_d    = 1'b1;
                        mem_wdata_d = alu_res;
                        state_d     = S_MEM_WR;
                    end else begin
                        retired_d = retired_inc;
                        prev_a_d  = 1'b0;
                        state_d   = S_FETCH;
                    end
                end
            end
            S_MEM_WR: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    retired_d = retired_inc;
                    prev_a_d  = 1'b0;
                    state_d   = S_FETCH;
                end
            end
            S_HALT: begin
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_FETCH;
            pc_q        <= '0;
            a_q         <= '0;
            d_q         <= '0;
            addr_q      <= '0;
            y_q         <= '0;
            ir_q        <= '0;
            retired_q   <= '0;
            halted_q    <= 1'b0;
            prev_a_q    <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            a_q         <= a_d;
            d_q         <= d_d;
            addr_q      <= addr_d;
            y_q         <= y_d;
            ir_q        <= ir_d;
            retired_q   <= retired_d;
            halted_q    <= halted_d;
            prev_a_q    <= prev_a_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign instr_req = (state_q == S_FETCH);
    assign pc        = pc_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = mem_wdata_q;
    assign halted    = halted_q;
    assign retired   = retired_q;

endmodule

// File: tb/tb_hack_cpu_param.sv
// Directed bench for hack_cpu_param: default core, a core with halt detection off,
// and a 32-bit data-path core, all driven from one sequential program.
module tb_hack_cpu_param;

    localparam logic [1:0] D0 = 2'd0;
    localparam logic [1:0] D1 = 2'd1;
    localparam logic [1:0] D2 = 2'd2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        iv    [3];
    logic [15:0] ins   [3];
    logic        ack   [3];
    logic [15:0] rd16  [2];
    logic [31:0] rd32;
    logic        ireq  [3];
    logic [14:0] pcw   [3];
    logic        mreq  [3];
    logic        mwe   [3];
    logic [15:0] ma16  [2];
    logic [15:0] mwd16 [2];
    logic [31:0] ma32, mwd32;
    logic        hlt   [3];
    logic [15:0] ret   [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hack_cpu_param u0 (
        .clk(clk), .reset_n(reset_n), .instr_req(ireq[0]), .instr_valid(iv[0]),
        .instruction(ins[0]), .pc(pcw[0]), .mem_req(mreq[0]), .mem_we(mwe[0]),
        .mem_ack(ack[0]), .mem_addr(ma16[0]), .mem_wdata(mwd16[0]), .mem_rdata(rd16[0]),
        .halted(hlt[0]), .retired(ret[0])
    );

    hack_cpu_param #(.HALT_DETECT(0)) u1 (
        .clk(clk), .reset_n(reset_n), .instr_req(ireq[1]), .instr_valid(iv[1]),
        .instruction(ins[1]), .pc(pcw[1]), .mem_req(mreq[1]), .mem_we(mwe[1]),
        .mem_ack(ack[1]), .mem_addr(ma16[1]), .mem_wdata(mwd16[1]), .mem_rdata(rd16[1]),
        .halted(hlt[1]), .retired(ret[1])
    );

    hack_cpu_param #(.DATA_W(32)) u2 (
        .clk(clk), .reset_n(reset_n), .instr_req(ireq[2]), .instr_valid(iv[2]),
        .instruction(ins[2]), .pc(pcw[2]), .mem_req(mreq[2]), .mem_we(mwe[2]),
        .mem_ack(ack[2]), .mem_addr(ma32), .mem_wdata(mwd32), .mem_rdata(rd32),
        .halted(hlt[2]), .retired(ret[2])
    );

    function automatic logic [31:0] get_ma(input logic [1:0] s);
        if (s == D2) return ma32;
        return {16'h0, ma16[s[0]]};
    endfunction

    function automatic logic [31:0] get_mwd(input logic [1:0] s);
        if (s == D2) return mwd32;
        return {16'h0, mwd16[s[0]]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_fetch(input logic [1:0] s, output bit ok);
        int n;
        n = 0;
        while (!ireq[s] && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        ok = ireq[s];
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL fetch_timeout dut=%0d observed=instr_req_low expected=instr_req_high", s);
        end
    endtask

    task automatic exec_instr(input logic [1:0] s, input logic [15:0] w);
        bit ok;
        wait_fetch(s, ok);
        if (ok) begin
            iv[s]  = 1'b1;
            ins[s] = w;
            @(posedge clk);
            #1;
            iv[s]  = 1'b0;
        end
    endtask

    task automatic expect_fetch(input logic [1:0] s, input logic [31:0] epc,
                                input logic [31:0] eret, input string tag);
        bit ok;
        wait_fetch(s, ok);
        chk({tag, "_pc"}, {17'h0, pcw[s]}, epc);
        chk({tag, "_retired"}, {16'h0, ret[s]}, eret);
    endtask

    task automatic mem_service(input logic [1:0] s, input string tag, input logic we,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] rdata, input int delay);
        int n;
        n = 0;
        while (!mreq[s] && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_req"}, {31'h0, mreq[s]}, 32'h1);
        chk({tag, "_we"}, {31'h0, mwe[s]}, {31'h0, we});
        chk({tag, "_addr"}, get_ma(s), addr);
        if (we) chk({tag, "_wdata"}, get_mwd(s), wdata);
        repeat (delay) begin
            @(posedge clk);
            #1;
        end
        if (delay > 0) begin
            chk({tag, "_req_hold"}, {31'h0, mreq[s]}, 32'h1);
            chk({tag, "_addr_hold"}, get_ma(s), addr);
        end
        ack[s] = 1'b1;
        if (s == D2) rd32 = rdata;
        else rd16[s[0]] = rdata[15:0];
        @(posedge clk);
        #1;
        ack[s] = 1'b0;
        chk({tag, "_req_drop"}, {31'h0, mreq[s]}, 32'h0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset_n = 1'b0;
        rd32    = '0;
        for (int i = 0; i < 3; i++) begin
            iv[i]  = 1'b0;
            ins[i] = '0;
            ack[i] = 1'b0;
        end
        rd16[0] = '0;
        rd16[1] = '0;

        // reset state
        #12;
        chk("rst_instr_req", {31'h0, ireq[0]}, 32'h1);
        chk("rst_pc", {17'h0, pcw[0]}, 32'h0);
        chk("rst_retired", {16'h0, ret[0]}, 32'h0);
        chk("rst_halted", {31'h0, hlt[0]}, 32'h0);
        chk("rst_mem_req", {31'h0, mreq[0]}, 32'h0);
        chk("rst_mem_we", {31'h0, mwe[0]}, 32'h0);
        chk("rst_mem_addr", get_ma(D0), 32'h0);
        chk("rst_mem_wdata", get_mwd(D0), 32'h0);
        chk("rst_mem_wdata32", get_mwd(D2), 32'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle(1);
        chk("instr_req_after_reset", {31'h0, ireq[0]}, 32'h1);

        // @5, D=A, @7, D=D+A, @0, M=D with a 3-cycle ack delay
        exec_instr(D0, 16'h0005);
        exec_instr(D0, 16'hEC10);
        exec_instr(D0, 16'h0007);
        exec_instr(D0, 16'hE090);
        exec_instr(D0, 16'h0000);
        exec_instr(D0, 16'hE308);
        mem_service(D0, "sum_wr", 1'b1, 32'd0, 32'd12, 32'd0, 3);
        expect_fetch(D0, 32'd6, 32'd6, "sum");

        // M[3]=0x00FF, then M=M+1 read-modify-write
        exec_instr(D0, 16'h00FF);
        exec_instr(D0, 16'hEC10);
        exec_instr(D0, 16'h0003);
        exec_instr(D0, 16'hE308);
        mem_service(D0, "rmw_init", 1'b1, 32'd3, 32'h00FF, 32'd0, 0);
        exec_instr(D0, 16'h0003);
        exec_instr(D0, 16'hFDC8);
        mem_service(D0, "rmw_rd", 1'b0, 32'd3, 32'd0, 32'h00FF, 2);
        idle(1);
        chk("rmw_gap", {31'h0, mreq[0]}, 32'h1);
        mem_service(D0, "rmw_wr", 1'b1, 32'd3, 32'h0100, 32'd0, 1);
        expect_fetch(D0, 32'd12, 32'd12, "rmw");

        // D;JGT not taken with D=-1, taken with D=1
        exec_instr(D0, 16'hEE90);
        exec_instr(D0, 16'h000A);
        exec_instr(D0, 16'hE301);
        expect_fetch(D0, 32'd15, 32'd15, "jgt_neg");
        exec_instr(D0, 16'hEFD0);
        exec_instr(D0, 16'h000A);
        exec_instr(D0, 16'hE301);
        expect_fetch(D0, 32'd10, 32'd18, "jgt_pos");

        // reach pc=20, then @20; 0;JMP halts
        exec_instr(D0, 16'h0014);
        exec_instr(D0, 16'hEA87);
        expect_fetch(D0, 32'd20, 32'd20, "jmp20");
        exec_instr(D0, 16'h0014);
        exec_instr(D0, 16'hEA87);
        idle(3);
        chk("halt_flag", {31'h0, hlt[0]}, 32'h1);
        chk("halt_pc", {17'h0, pcw[0]}, 32'd21);
        chk("halt_retired", {16'h0, ret[0]}, 32'd22);
        iv[0]  = 1'b1;
        ins[0] = 16'h0001;
        for (int i = 0; i < 4; i++) begin
            chk("halt_no_instr_req", {31'h0, ireq[0]}, 32'h0);
            chk("halt_no_mem_req", {31'h0, mreq[0]}, 32'h0);
            idle(1);
        end
        iv[0] = 1'b0;
        chk("halt_retired_frozen", {16'h0, ret[0]}, 32'd22);

        // same loop with halt detection disabled keeps running
        exec_instr(D1, 16'h0014);
        exec_instr(D1, 16'hEA87);
        expect_fetch(D1, 32'd20, 32'd2, "nohalt_entry");
        for (int p = 1; p <= 3; p++) begin
            exec_instr(D1, 16'h0014);
            exec_instr(D1, 16'hEA87);
            expect_fetch(D1, 32'd20, 32'(2 + 2 * p), "nohalt_pass");
            chk("nohalt_flag", {31'h0, hlt[1]}, 32'h0);
        end

        // 32-bit data path: D=-1, D=D+1 gives zero, pc wrap, self-jump halt
        exec_instr(D2, 16'hEE90);
        exec_instr(D2, 16'h0007);
        exec_instr(D2, 16'hE308);
        mem_service(D2, "w32_neg1", 1'b1, 32'd7, 32'hFFFF_FFFF, 32'd0, 0);
        exec_instr(D2, 16'hE7D0);
        exec_instr(D2, 16'h0064);
        exec_instr(D2, 16'hE302);
        expect_fetch(D2, 32'd100, 32'd6, "w32_jeq");
        exec_instr(D2, 16'hE308);
        mem_service(D2, "w32_zero", 1'b1, 32'd100, 32'd0, 32'd0, 1);
        exec_instr(D2, 16'h7FFF);
        exec_instr(D2, 16'hEA87);
        expect_fetch(D2, 32'h7FFF, 32'd9, "w32_pc_top");
        exec_instr(D2, 16'h0005);
        expect_fetch(D2, 32'd0, 32'd10, "w32_pc_wrap");
        exec_instr(D2, 16'h0001);
        exec_instr(D2, 16'hEA87);
        idle(3);
        chk("selfjump_halt", {31'h0, hlt[2]}, 32'h1);
        chk("selfjump_pc", {17'h0, pcw[2]}, 32'd1);
        chk("selfjump_retired", {16'h0, ret[2]}, 32'd12);
        chk("selfjump_no_instr_req", {31'h0, ireq[2]}, 32'h0);

        // reset leaves HALT
        reset_n = 1'b0;
        #1;
        chk("rst2_halted", {31'h0, hlt[0]}, 32'h0);
        chk("rst2_pc", {17'h0, pcw[0]}, 32'h0);
        chk("rst2_instr_req", {31'h0, ireq[0]}, 32'h1);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // reset during a pending read abandons it
        exec_instr(D0, 16'h0009);
        exec_instr(D0, 16'hEC10);
        exec_instr(D0, 16'h0009);
        exec_instr(D0, 16'hFC10);
        n = 0;
        while (!mreq[0] && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("abort_req_seen", {31'h0, mreq[0]}, 32'h1);
        #3;
        reset_n = 1'b0;
        #1;
        chk("abort_req_async_drop", {31'h0, mreq[0]}, 32'h0);
        chk("abort_pc", {17'h0, pcw[0]}, 32'h0);
        chk("abort_retired", {16'h0, ret[0]}, 32'h0);
        chk("abort_mem_addr", get_ma(D0), 32'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle(1);
        chk("abort_instr_req", {31'h0, ireq[0]}, 32'h1);
        exec_instr(D0, 16'hE308);
        mem_service(D0, "abort_ad_zero", 1'b1, 32'd0, 32'd0, 32'd0, 0);
        expect_fetch(D0, 32'd1, 32'd1, "abort_after");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
